// File: rtl/sub_seq_32bit.sv
// rtl/sub_seq_32bit.sv - multicycle 32-bit subtractor, one SLICE_W-bit ripple slice per clock
// Optional feature macro: OVF_FLAG_EN adds the signed-overflow port and register.
`timescale 1ns/1ps
module sub_seq_32bit #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] D,
  output logic        Bout
`ifdef OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);
  localparam int NSL = 32 / SLICE_W;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [KW-1:0]      k;
  logic [31:0]        a_r, b_r;
  logic               c;
  logic [SLICE_W-1:0] a_s, b_s;
  logic [SLICE_W:0]   sum;
  logic               last;

  // Subtraction as a + ~b + carry, carry seeded with ~bin.
  assign a_s  = a_r[k*SLICE_W +: SLICE_W];
  assign b_s  = b_r[k*SLICE_W +: SLICE_W];
  assign sum  = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE_W{1'b0}}, c};
  assign last = (k == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k    <= '0;
      a_r  <= '0;
      b_r  <= '0;
      c    <= 1'b0;
      D    <= '0;
      Bout <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf  <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_r <= a;
      b_r <= b;
      c   <= ~bin;
      k   <= '0;
    end else if (state == RUN) begin
      D[k*SLICE_W +: SLICE_W] <= sum[SLICE_W-1:0];
      c <= sum[SLICE_W];
      k <= k + 1'b1;
      if (last) begin
        Bout <= ~sum[SLICE_W];
`ifdef OVF_FLAG_EN
        // Top slice carries bit 31, so sum[SLICE_W-1] is the final D[31].
        ovf <= (a_r[31] ^ b_r[31]) & (sum[SLICE_W-1] ^ a_r[31]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_sub_seq_32bit.sv
// tb/tb_sub_seq_32bit.sv - scoreboard bench for sub_seq_32bit with randomized operands
`timescale 1ns/1ps
module tb_sub_seq_32bit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        bin;
  logic        busy, done;
  logic [31:0] D;
  logic        Bout;
`ifdef OVF_FLAG_EN
  logic        ovf;
`endif

  sub_seq_32bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
`ifdef OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   lat, bc;

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    exp_t e;
    logic [32:0] diff;
    diff   = {1'b0, ma} - {1'b0, mb} - 33'(mbin);
    e.d    = diff[31:0];
    e.bout = ({1'b0, ma} < ({1'b0, mb} + 33'(mbin)));
    e.ovf  = (ma[31] != mb[31]) && (e.d[31] != ma[31]);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: consumes one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending request (D=%0h)", D);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_D", 64'(D), 64'(e.d));
          chk("sb_Bout", 64'(Bout), 64'(e.bout));
`ifdef OVF_FLAG_EN
          chk("sb_ovf", 64'(ovf), 64'(e.ovf));
`endif
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("idle_timeout", 64'(busy | done), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tbin,
                        output int olat, output int obc);
    wait_idle();
    a = ta; b = tb2; bin = tbin; start = 1'b1;
    last_exp = model(ta, tb2, tbin);
    sb.push_back(last_exp);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    olat = 1;
    obc  = busy ? 1 : 0;
    while (!done && olat < 20) begin
      @(negedge clk);
      olat++;
      if (busy) obc++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int gap;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_D", 64'(D), 64'd0);
    chk("rst_Bout", 64'(Bout), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'hFFFF_FFFF, 32'd967295, 1'b0, lat, bc);
    chk("latency", 64'(lat), 64'd5);
    chk("busy_cycles", 64'(bc), 64'd4);
    chk("tp1_D", 64'(D), 64'd4294000000);
    repeat (3) @(negedge clk);
    chk("hold_D", 64'(D), 64'(last_exp.d));
    chk("hold_Bout", 64'(Bout), 64'(last_exp.bout));

    run_op(32'd0, 32'd1, 1'b0, lat, bc);
    chk("zero_minus_one_D", 64'(D), 64'hFFFF_FFFF);
    chk("zero_minus_one_Bout", 64'(Bout), 64'd1);
    run_op(32'd42400430, 32'd429, 1'b1, lat, bc);
    chk("bin_D", 64'(D), 64'd42400000);
    chk("bin_Bout", 64'(Bout), 64'd0);
    run_op(32'd5, 32'd5, 1'b1, lat, bc);
    chk("eq_bin_D", 64'(D), 64'hFFFF_FFFF);
    chk("eq_bin_Bout", 64'(Bout), 64'd1);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0, lat, bc);
    chk("slice_ripple_D", 64'(D), 64'h0000_00FF);
    chk("slice_ripple_Bout", 64'(Bout), 64'd0);

    // Second start while busy must be dropped.
    wait_idle();
    gap = done_cnt;
    a = 32'd10; b = 32'd3; bin = 1'b0; start = 1'b1;
    sb.push_back(model(32'd10, 32'd3, 1'b0));
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 32'd1; b = 32'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    chk("ignored_done_count", 64'(done_cnt - gap), 64'd1);
    chk("ignored_D", 64'(D), 64'd7);
    chk("ignored_Bout", 64'(Bout), 64'd0);

    // Held start re-triggers straight after DONE.
    wait_idle();
    a = 32'h1234_5678; b = 32'h0FED_CBA9; bin = 1'b1; start = 1'b1;
    sb.push_back(model(a, b, bin));
    sb.push_back(model(a, b, bin));
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("held_first_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("held_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    chk("held_retrigger", 64'(busy), 64'd1);
    start = 1'b0; a = $urandom; b = $urandom;
    gap = 2;
    while (!done && gap < 20) begin @(negedge clk); gap++; end
    chk("throughput_gap", 64'(gap), 64'd6);

    // Asynchronous reset in the second RUN cycle.
    wait_idle();
    a = 32'd100; b = 32'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("pre_abort_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_D", 64'(D), 64'd0);
    chk("abort_Bout", 64'(Bout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op(32'd100, 32'd1, 1'b0, lat, bc);
    chk("post_abort_D", 64'(D), 64'd99);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      run_op(ra, rb, 1'($urandom), lat, bc);
    end

`ifdef OVF_FLAG_EN
    run_op(32'h8000_0000, 32'd1, 1'b0, lat, bc);
    chk("ovf1_D", 64'(D), 64'h7FFF_FFFF);
    chk("ovf1_ovf", 64'(ovf), 64'd1);
    chk("ovf1_Bout", 64'(Bout), 64'd0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
    chk("ovf2_D", 64'(D), 64'h8000_0000);
    chk("ovf2_ovf", 64'(ovf), 64'd1);
    chk("ovf2_Bout", 64'(Bout), 64'd1);
    run_op(32'd3, 32'd1, 1'b0, lat, bc);
    chk("ovf3_ovf", 64'(ovf), 64'd0);
`endif

    repeat (10) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
